path_stack_ctrl: RTL and testbench

- Sequences the location stack used by the maze-solver controller.
- Solve phase: services the solver's push/pop requests (with simultaneous-request resolution and overflow/underflow protection) and presents the current top of stack.
- After the solver reports done: replays the stored path bottom-to-top (start cell to destination) over a valid/ready stream to the downstream path consumer.
- Sits between the controller's push/pop/empStck signals and an internal LIFO array.

---
 rtl/path_stack_ctrl_if.sv | 31 +++
 rtl/path_stack_ctrl.sv | 136 +++++++++++++
 tb/tb_path_stack_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/path_stack_ctrl_if.sv
// Bundles the solver-side stack requests, replay control and the path replay stream
// that connect the maze-solver controller to path_stack_ctrl.
interface path_stack_ctrl_if #(
  parameter int LOC_W = 8
);
  logic             clear;
  logic             push;
  logic             pop;
  logic [LOC_W-1:0] dIn;
  logic             startReplay;
  logic             outReady;
  logic [LOC_W-1:0] topLoc;
  logic             empStck;
  logic             fullStck;
  logic             outValid;
  logic [LOC_W-1:0] outLoc;
  logic             replayDone;
  logic             busy;
  logic             ovf;
  logic             unf;

  modport master (
    output clear, push, pop, dIn, startReplay, outReady,
    input  topLoc, empStck, fullStck, outValid, outLoc, replayDone, busy, ovf, unf
  );

  modport slave (
    input  clear, push, pop, dIn, startReplay, outReady,
    output topLoc, empStck, fullStck, outValid, outLoc, replayDone, busy, ovf, unf
  );
endinterface

// File: rtl/path_stack_ctrl.sv
// Location stack for the maze solver: push/pop service while solving, then a bottom-to-top
// valid/ready replay of the stored path. Define STACK_PROT_EN for sticky ovf/unf flags.
module path_stack_ctrl #(
  parameter int LOC_W = 8,
  parameter int DEPTH = 64
) (
  input logic             clk,
  input logic             rst,
  path_stack_ctrl_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_SP = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_SP  = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_A   = AW'(1);

  typedef enum logic [1:0] {IDLE, REPLAY, DONE} state_t;

  state_t           state, nextState;
  logic [AW:0]      sp, rdPtr;
  logic [LOC_W-1:0] mem [DEPTH];
  logic [LOC_W-1:0] outLocR;
  logic             outValidR;
  logic             empty, full, xfer, solveEn;
  logic             doPush, doRepl, doPop, wrEn;
  logic [AW-1:0]    topIdx, wrAddr;

  assign empty   = (sp == '0);
  assign full    = (sp == FULL_SP);
  assign xfer    = outValidR && bus.outReady;
  assign topIdx  = sp[AW-1:0] - ONE_A;
  // startReplay and clear both pre-empt any solver request in the same cycle
  assign solveEn = (state == IDLE) && !bus.clear && !bus.startReplay;
  assign doPush  = solveEn && bus.push && !full && (!bus.pop || empty);
  assign doRepl  = solveEn && bus.push && bus.pop && !empty;
  assign doPop   = solveEn && bus.pop && !bus.push && !empty;
  assign wrEn    = doPush || doRepl;
  assign wrAddr  = doRepl ? topIdx : sp[AW-1:0];

  assign bus.topLoc   = empty ? '0 : mem[topIdx];
  assign bus.empStck  = empty;
  assign bus.fullStck = full;
  assign bus.outValid = outValidR;
  assign bus.outLoc   = outLocR;

  always_ff @(posedge clk) begin
    if (wrEn) mem[wrAddr] <= bus.dIn;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nextState;
  end

  always_comb begin
    nextState = state;
    if (bus.clear) begin
      nextState = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.startReplay) nextState = empty ? DONE : REPLAY;
        REPLAY:  if (xfer && (rdPtr == sp)) nextState = DONE;
        DONE:    nextState = IDLE;
        default: nextState = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.busy       = (state != IDLE);
    bus.replayDone = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp        <= '0;
      rdPtr     <= '0;
      outValidR <= 1'b0;
      outLocR   <= '0;
    end else if (bus.clear) begin
      sp        <= '0;
      rdPtr     <= '0;
      outValidR <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.startReplay) begin
            if (!empty) begin
              outLocR   <= mem[0];
              outValidR <= 1'b1;
              rdPtr     <= ONE_SP;
            end
          end else if (doPush) begin
            sp <= sp + ONE_SP;
          end else if (doPop) begin
            sp <= sp - ONE_SP;
          end
        end
        REPLAY: begin
          // rdPtr always points at the entry after the one currently on outLoc
          if (xfer) begin
            if (rdPtr < sp) begin
              outLocR <= mem[rdPtr[AW-1:0]];
              rdPtr   <= rdPtr + ONE_SP;
            end else begin
              outValidR <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef STACK_PROT_EN
  logic ovfR, unfR;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovfR <= 1'b0;
      unfR <= 1'b0;
    end else if (bus.clear) begin
      ovfR <= 1'b0;
      unfR <= 1'b0;
    end else begin
      if (solveEn && bus.push && !bus.pop && full)  ovfR <= 1'b1;
      if (solveEn && bus.pop && !bus.push && empty) unfR <= 1'b1;
    end
  end

  assign bus.ovf = ovfR;
  assign bus.unf = unfR;
`else
  assign bus.ovf = 1'b0;
  assign bus.unf = 1'b0;
`endif
endmodule

// File: tb/tb_path_stack_ctrl.sv
// Directed bench for path_stack_ctrl: replay stream checked by a queue-based scoreboard
// monitor, stack/flag/handshake behaviour checked by directed comparisons.
module tb_path_stack_ctrl;
  logic clk;
  logic rst;
  int   nCmp = 0;
  int   nErr = 0;
  logic [7:0] expQ [$];

  path_stack_ctrl_if #(.LOC_W(8)) bus();

  path_stack_ctrl #(.LOC_W(8), .DEPTH(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef STACK_PROT_EN
  localparam logic PROT = 1'b1;
`else
  localparam logic PROT = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doPush(input logic [7:0] d);
    bus.push = 1'b1;
    bus.dIn  = d;
    step();
    bus.push = 1'b0;
  endtask

  // Scoreboard monitor: every accepted replay beat is popped and compared.
  initial begin
    forever begin
      @(negedge clk);
      if (rst && bus.outValid && bus.outReady) begin
        if (expQ.size() == 0) begin
          chk("unexpected_beat", {24'h0, bus.outLoc}, 32'hFFFF_FFFF);
        end else begin
          chk("replay_beat", {24'h0, bus.outLoc}, {24'h0, expQ.pop_front()});
        end
      end
    end
  end

  initial begin
    rst = 1'b0;
    bus.clear = 1'b0; bus.push = 1'b0; bus.pop = 1'b0;
    bus.dIn = 8'h00; bus.startReplay = 1'b0; bus.outReady = 1'b0;
    step(); step();
    chk("rst_outValid",   bus.outValid,   0);
    chk("rst_outLoc",     bus.outLoc,     0);
    chk("rst_replayDone", bus.replayDone, 0);
    chk("rst_busy",       bus.busy,       0);
    chk("rst_ovf",        bus.ovf,        0);
    chk("rst_unf",        bus.unf,        0);
    chk("rst_empStck",    bus.empStck,    1);
    chk("rst_topLoc",     bus.topLoc,     0);
    rst = 1'b1;
    step();

    // Solve-phase push / pop / replace
    doPush(8'h00); doPush(8'h01); doPush(8'h11);
    chk("push3_topLoc",  bus.topLoc,  8'h11);
    chk("push3_empStck", bus.empStck, 0);
    bus.pop = 1'b1; step(); bus.pop = 1'b0;
    chk("pop_topLoc", bus.topLoc, 8'h01);
    bus.pop = 1'b1; doPush(8'h12); bus.pop = 1'b0;
    chk("replace_topLoc", bus.topLoc, 8'h12);
    bus.pop = 1'b1; step(); bus.pop = 1'b0;
    chk("replace_sp2_topLoc", bus.topLoc, 8'h00);
    doPush(8'h12); doPush(8'h22);
    chk("stack3_topLoc", bus.topLoc, 8'h22);

    // Full-rate replay
    expQ.push_back(8'h00); expQ.push_back(8'h12); expQ.push_back(8'h22);
    bus.outReady = 1'b1; bus.startReplay = 1'b1; step(); bus.startReplay = 1'b0;
    chk("rep_first_valid", bus.outValid, 1);
    chk("rep_first_loc",   bus.outLoc,   8'h00);
    chk("rep_busy",        bus.busy,     1);
    step(); step();
    chk("rep_last_loc",    bus.outLoc,     8'h22);
    chk("rep_noDoneYet",   bus.replayDone, 0);
    step();
    chk("rep_done_pulse",  bus.replayDone, 1);
    chk("rep_done_valid",  bus.outValid,   0);
    step();
    chk("rep_done_end",    bus.replayDone, 0);
    chk("rep_idle_busy",   bus.busy,       0);
    chk("rep_kept_top",    bus.topLoc,     8'h22);
    chk("rep_queue_empty", expQ.size(),    0);

    // Replay with a 3-cycle stall on the second entry
    expQ.push_back(8'h00); expQ.push_back(8'h12); expQ.push_back(8'h22);
    bus.startReplay = 1'b1; step(); bus.startReplay = 1'b0;
    step();
    bus.outReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_valid", bus.outValid, 1);
      chk("stall_loc",   bus.outLoc,   8'h12);
    end
    bus.outReady = 1'b1;
    step();
    chk("stall_next_loc", bus.outLoc, 8'h22);
    step();
    chk("stall_done", bus.replayDone, 1);
    step();
    chk("stall_queue_empty", expQ.size(), 0);

    // Clear mid-replay (second beat is accepted on the clear edge)
    expQ.push_back(8'h00); expQ.push_back(8'h12);
    bus.startReplay = 1'b1; step(); bus.startReplay = 1'b0;
    step();
    bus.clear = 1'b1; step(); bus.clear = 1'b0;
    chk("clr_outValid",   bus.outValid,   0);
    chk("clr_empStck",    bus.empStck,    1);
    chk("clr_busy",       bus.busy,       0);
    chk("clr_replayDone", bus.replayDone, 0);
    step();
    chk("clr_noDone", bus.replayDone, 0);
    chk("clr_queue_empty", expQ.size(), 0);

    // Overflow: 65 pushes into a 64-deep stack
    for (int i = 0; i < 65; i++) doPush(8'(i));
    chk("ovf_full",   bus.fullStck, 1);
    chk("ovf_topLoc", bus.topLoc,   8'h3F);
    chk("ovf_flag",   bus.ovf,      PROT);
    bus.clear = 1'b1; step(); bus.clear = 1'b0;
    chk("ovf_cleared", bus.ovf,    0);
    chk("clr_notFull", bus.fullStck, 0);

    // Underflow, then simultaneous push/pop on empty acts as push
    bus.pop = 1'b1; step(); bus.pop = 1'b0;
    chk("unf_flag",  bus.unf,     PROT);
    chk("unf_empty", bus.empStck, 1);
    bus.pop = 1'b1; doPush(8'h5A); bus.pop = 1'b0;
    chk("pp_empty_topLoc", bus.topLoc,  8'h5A);
    chk("pp_empty_nonEmp", bus.empStck, 0);
    chk("unf_sticky",      bus.unf,     PROT);
    bus.clear = 1'b1; step(); bus.clear = 1'b0;

    // Replay of an empty stack
    bus.startReplay = 1'b1; step(); bus.startReplay = 1'b0;
    chk("empty_rep_valid", bus.outValid,   0);
    chk("empty_rep_done",  bus.replayDone, 1);
    step();
    chk("empty_rep_end",   bus.replayDone, 0);
    chk("empty_rep_busy",  bus.busy,       0);

    // Asynchronous reset mid-replay
    doPush(8'h31); doPush(8'h32); doPush(8'h33);
    bus.startReplay = 1'b1; step(); bus.startReplay = 1'b0;
    chk("arst_pre_valid", bus.outValid, 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_outValid",   bus.outValid,   0);
    chk("arst_outLoc",     bus.outLoc,     0);
    chk("arst_busy",       bus.busy,       0);
    chk("arst_replayDone", bus.replayDone, 0);
    chk("arst_topLoc",     bus.topLoc,     0);
    chk("arst_empStck",    bus.empStck,    1);
    step();
    rst = 1'b1;
    step();
    chk("final_queue_empty", expQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end
endmodule
